dm_sized_pipe: RTL and testbench

//  Parametrised data memory for the single-cycle/pipelined CPU projects.
//  Big-endian, byte-addressed; byte/half/word loads and stores with signed or unsigned load extension.

---
 rtl/dm_sized_pipe.sv | 152 +++++++++++++++
 tb/tb_dm_sized_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sized_pipe.sv
// Big-endian byte-addressed data memory with a valid/ready request port,
// fixed-latency in-order response pipeline, fault detection and optional clear after reset.
module dm_sized_pipe #(
   parameter int MEM_BYTES      = 128,
   parameter int READ_LAT       = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_fault,
   output logic        dbg_state
);

   localparam int AW    = $clog2(MEM_BYTES);
   localparam int WORDS = MEM_BYTES / 4;
   localparam int CW    = $clog2(WORDS);

   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t          state_q;
   logic [CW-1:0]   clr_cnt_q;
   logic            ready_q;
   logic [7:0]      mem_q [MEM_BYTES];

   logic            accept;
   logic [2:0]      nbytes;
   logic [32:0]     end_addr;
   logic [1:0]      fault_c;
   logic [AW-1:0]   a0, a1, a2, a3;
   logic [7:0]      b0, b1, b2, b3;
   logic [31:0]     load_data;
   logic [31:0]     rdata_c;
   logic            st_we;

   logic            v_q [READ_LAT];
   logic [31:0]     d_q [READ_LAT];
   logic [1:0]      f_q [READ_LAT];

   always_comb begin
      accept = req_valid && ready_q;
      case (req_size)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      // 33-bit sum so addresses near 2^32 cannot wrap back into range
      end_addr = {1'b0, req_addr} + {30'd0, nbytes} - 33'd1;
      if (req_size == 2'b11)
         fault_c = 2'b11;
      else if ((req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00))
         fault_c = 2'b01;
      else if (end_addr >= 33'(MEM_BYTES))
         fault_c = 2'b10;
      else
         fault_c = 2'b00;

      a0 = req_addr[AW-1:0];
      a1 = a0 + AW'(1);
      a2 = a0 + AW'(2);
      a3 = a0 + AW'(3);
      b0 = mem_q[a0];
      b1 = mem_q[a1];
      b2 = mem_q[a2];
      b3 = mem_q[a3];
      case (req_size)
         2'b00:   load_data = {{24{~req_unsigned & b0[7]}}, b0};
         2'b01:   load_data = {{16{~req_unsigned & b0[7]}}, b0, b1};
         default: load_data = {b0, b1, b2, b3};
      endcase
      rdata_c = (!req_we && fault_c == 2'b00) ? load_data : 32'd0;
      st_we   = accept && req_we && (fault_c == 2'b00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + CW'(1);
               if (clr_cnt_q == CW'(WORDS - 1)) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: ready_q <= 1'b1;
         endcase
      end
   end

   // Storage has no reset; only the clear sequence or committed stores change it.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[{clr_cnt_q, 2'd0}] <= 8'd0;
         mem_q[{clr_cnt_q, 2'd1}] <= 8'd0;
         mem_q[{clr_cnt_q, 2'd2}] <= 8'd0;
         mem_q[{clr_cnt_q, 2'd3}] <= 8'd0;
      end else if (st_we) begin
         case (req_size)
            2'b00: mem_q[a0] <= req_wdata[7:0];
            2'b01: begin
               mem_q[a0] <= req_wdata[15:8];
               mem_q[a1] <= req_wdata[7:0];
            end
            default: begin
               mem_q[a0] <= req_wdata[31:24];
               mem_q[a1] <= req_wdata[23:16];
               mem_q[a2] <= req_wdata[15:8];
               mem_q[a3] <= req_wdata[7:0];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < READ_LAT; i++) begin
            v_q[i] <= 1'b0;
            d_q[i] <= '0;
            f_q[i] <= '0;
         end
      end else begin
         v_q[0] <= accept;
         d_q[0] <= accept ? rdata_c : 32'd0;
         f_q[0] <= accept ? fault_c : 2'b00;
         for (int i = 1; i < READ_LAT; i++) begin
            v_q[i] <= v_q[i-1];
            d_q[i] <= d_q[i-1];
            f_q[i] <= f_q[i-1];
         end
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = v_q[READ_LAT-1];
   assign rsp_rdata = d_q[READ_LAT-1];
   assign rsp_fault = f_q[READ_LAT-1];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_sized_pipe.sv
// Bench for dm_sized_pipe: directed cases plus random traffic scored against
// a byte-array memory model with a due-cycle expected-response queue.
module tb_dm_sized_pipe;

   localparam int MEM = 128;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_fault;
   logic        dbg_state;

   always #5 clk = ~clk;

   dm_sized_pipe #(.MEM_BYTES(MEM), .READ_LAT(LAT), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .dbg_state(dbg_state)
   );

   typedef struct packed {
      logic [31:0] due;
      logic [31:0] rdata;
      logic [1:0]  fault;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  model_mem [MEM];
   int unsigned cyc = 0;
   int unsigned log_cyc[$];
   logic [31:0] log_dat[$];
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: fault rules and big-endian byte assembly from plain arithmetic.
   function automatic exp_t model_access(input logic we, input logic [1:0] size,
                                         input logic uns, input logic [31:0] addr,
                                         input logic [31:0] wdata);
      exp_t e;
      int n;
      longint unsigned last;
      logic [31:0] val;
      e = '0;
      n = 1 << size;
      last = {32'd0, addr} + longint'(n) - 1;
      if (size == 2'b11) e.fault = 2'b11;
      else if (addr % n != 0) e.fault = 2'b01;
      else if (last >= MEM) e.fault = 2'b10;
      else if (we) begin
         for (int i = 0; i < n; i++)
            model_mem[addr + i] = 8'(wdata >> (8 * (n - 1 - i)));
      end else begin
         val = 0;
         for (int i = 0; i < n; i++) val = (val << 8) | 32'(model_mem[addr + i]);
         if (!uns && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 1);
         e.rdata = val;
      end
      return e;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         for (int i = 0; i < MEM; i++) model_mem[i] = 8'd0;
      end else begin
         cyc++;
         if (req_valid && req_ready) begin
            e = model_access(req_we, req_size, req_unsigned, req_addr, req_wdata);
            e.due = cyc + LAT - 1;
            exp_q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      logic exp_v;
      if (!rst_n) begin
         exp_q.delete();
         check("rsp_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
      end else begin
         exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
         if (exp_v) begin
            e = exp_q.pop_front();
            if (rsp_valid) begin
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_fault", {30'd0, rsp_fault}, {30'd0, e.fault});
            end
         end
         if (rsp_valid) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(rsp_rdata);
         end
      end
   end

   // Holds reset for some cycles, releases it and measures the clear window.
   task automatic reset_and_count(input int hold);
      int cnt;
      rst_n = 1'b0;
      #1;
      check("reset_ready", {31'd0, req_ready}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_fault", {30'd0, rsp_fault}, 32'd0);
      repeat (hold) @(posedge clk);
      #1 rst_n = 1'b1;
      cnt = 0;
      while (cnt < 100) begin
         @(negedge clk);
         if (req_ready) break;
         cnt++;
      end
      check("clear_cycles", cnt, 32);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1;
      req_we = we;
      req_size = size;
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic access(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic [1:0] f);
      bit got;
      got = 0;
      rd = 'x;
      f = 'x;
      drive(we, size, uns, addr, wdata);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            rd = rsp_rdata;
            f = rsp_fault;
            got = 1;
            break;
         end
      end
      if (!got) check("rsp_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  f;
      int unsigned n0;

      reset_and_count(3);
      access(0, 2'b10, 0, 32'h7C, 0, rd, f);
      check("t1_lw_7c", rd, 32'h0);
      check("t1_lw_7c_fault", {30'd0, f}, 32'd0);

      access(1, 2'b10, 0, 32'h10, 32'h8081_7F01, rd, f);
      access(0, 2'b00, 0, 32'h10, 0, rd, f);
      check("t2_lb", rd, 32'hFFFF_FF80);
      access(0, 2'b00, 1, 32'h11, 0, rd, f);
      check("t2_lbu", rd, 32'h0000_0081);
      access(0, 2'b01, 0, 32'h12, 0, rd, f);
      check("t2_lh", rd, 32'h0000_7F01);
      access(0, 2'b01, 1, 32'h10, 0, rd, f);
      check("t2_lhu", rd, 32'h0000_8081);

      access(1, 2'b10, 0, 32'h20, 32'h1122_3344, rd, f);
      access(1, 2'b00, 0, 32'h21, 32'h0000_00AA, rd, f);
      access(0, 2'b10, 0, 32'h20, 0, rd, f);
      check("t3_sb", rd, 32'h11AA_3344);
      access(1, 2'b01, 0, 32'h22, 32'h0000_BEEF, rd, f);
      access(0, 2'b10, 0, 32'h20, 0, rd, f);
      check("t3_sh", rd, 32'h11AA_BEEF);

      access(0, 2'b10, 0, 32'h02, 0, rd, f);
      check("t4_lw_mis", {30'd0, f}, 32'd1);
      check("t4_lw_mis_data", rd, 32'd0);
      access(1, 2'b01, 0, 32'h7F, 32'h1234, rd, f);
      check("t4_sh_mis", {30'd0, f}, 32'd1);
      access(1, 2'b10, 0, 32'h80, 32'hDEAD_BEEF, rd, f);
      check("t4_sw_range", {30'd0, f}, 32'd2);
      access(0, 2'b10, 0, 32'h7C, 0, rd, f);
      check("t4_unchanged", rd, 32'd0);
      access(0, 2'b11, 0, 32'h03, 0, rd, f);
      check("t4_size11", {30'd0, f}, 32'd3);
      access(0, 2'b10, 0, 32'hFFFF_FFFC, 0, rd, f);
      check("t4_nowrap", {30'd0, f}, 32'd2);

      log_cyc.delete();
      log_dat.delete();
      n0 = cyc + 1;
      drive(1, 2'b10, 0, 32'h0, 32'hA0A0_0001);
      drive(1, 2'b10, 0, 32'h4, 32'hB0B0_0002);
      drive(1, 2'b10, 0, 32'h8, 32'hC0C0_0003);
      drive(0, 2'b10, 0, 32'h0, 0);
      drive(0, 2'b10, 0, 32'h4, 0);
      drive(0, 2'b10, 0, 32'h8, 0);
      repeat (LAT + 2) @(posedge clk);
      #1;
      check("t5_count", log_cyc.size(), 6);
      if (log_cyc.size() == 6) begin
         for (int i = 0; i < 6; i++) check("t5_cycle", log_cyc[i], n0 + LAT - 1 + i);
         check("t5_lw0", log_dat[3], 32'hA0A0_0001);
         check("t5_lw4", log_dat[4], 32'hB0B0_0002);
         check("t5_lw8", log_dat[5], 32'hC0C0_0003);
      end

      access(1, 2'b10, 0, 32'h40, 32'h5555_AAAA, rd, f);
      log_cyc.delete();
      drive(0, 2'b10, 0, 32'h40, 0);
      drive(0, 2'b10, 0, 32'h00, 0);
      reset_and_count(4);
      check("t6_dropped", log_cyc.size(), 0);
      rst_n = 1'b0;
      #10 rst_n = 1'b1;
      repeat (16) @(posedge clk);
      #1;
      reset_and_count(2);
      access(0, 2'b10, 0, 32'h40, 0, rd, f);
      check("t6_cleared", rd, 32'd0);

      for (int it = 0; it < 400; it++) begin
         logic [1:0] sz;
         logic [31:0] a;
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0: a = $urandom;
            1: a = $urandom_range(0, MEM + 7);
            default: a = $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
         req_valid = ($urandom_range(0, 3) != 0);
         req_we = 1'($urandom_range(0, 1));
         req_size = sz;
         req_unsigned = 1'($urandom_range(0, 1));
         req_addr = a;
         req_wdata = $urandom;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
